// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider.
//   MIN_DIV            smallest legal divide ratio
//   ST_IDLE / ST_PEND  encodings of the ratio-load FSM
//   load_state_e       FSM state type, built on those encodings
package clk_div_pkg;
  localparam int MIN_DIV = 2;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_PEND = 1'b1;

  typedef enum logic {
    IDLE = ST_IDLE,
    PEND = ST_PEND
  } load_state_e;
endpackage

// File: rtl/clk_div_if.sv
// Control/status bundle of the programmable clock divider.
//   en, div_val, div_load                    : requester -> divider
//   load_ack, load_err, clk_out, tick,
//   cur_div, dbg_state                       : divider -> requester
// Handshake: div_load is a single-cycle request with no ready. The divider
// always samples it; the request later completes with a one-cycle load_ack
// (ratio now in force) or is refused on the next cycle with load_err
// (div_val < 2). A newer accepted request replaces one still pending.
interface clk_div_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic [CNT_W-1:0] div_val;
  logic             div_load;
  logic             load_ack;
  logic             load_err;
  logic             clk_out;
  logic             tick;
  logic [CNT_W-1:0] cur_div;
  logic             dbg_state;

  modport master (
    output en, div_val, div_load,
    input  load_ack, load_err, clk_out, tick, cur_div, dbg_state
  );

  modport slave (
    input  en, div_val, div_load,
    output load_ack, load_err, clk_out, tick, cur_div, dbg_state
  );
endinterface

// File: rtl/clk_div_core.sv
// Counter and waveform generator of the divider.
//   clk, rst   : clock, asynchronous active-low reset
//   en         : count enable, 0 freezes counter and clk_out
//   div        : ratio N in force
//   wrap       : combinational, last cycle of the current period
//   clk_out    : registered divided clock, low for N-(N>>1), high for N>>1
//   tick       : registered one-cycle strobe, coincides with clk_out falling
module clk_div_core #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div,
  output logic             wrap,
  output logic             clk_out,
  output logic             tick
);
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] low_len;

  // Odd ratios put the extra cycle in the low phase.
  assign low_len = div - (div >> 1);
  assign wrap    = en && (cnt == div - 1'b1);

  always_comb begin
    cnt_next = cnt;
    if (en) begin
      cnt_next = wrap ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      tick <= wrap;
      // Compare against the post-update count so clk_out is aligned with cnt;
      // at a wrap cnt_next is 0, so a new ratio can never shorten a high phase.
      if (en) begin
        clk_out <= (cnt_next >= low_len);
      end
    end
  end
endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : clk_div_if slave (en, div_val, div_load in;
//              load_ack, load_err, clk_out, tick, cur_div, dbg_state out)
// A new ratio is held pending and only enters force at a period boundary.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input logic       clk,
  input logic       rst,
  clk_div_if.slave  bus
);
  localparam logic [CNT_W-1:0] MIN_DIV_W = CNT_W'(MIN_DIV);
  localparam logic [CNT_W-1:0] DEF_DIV_W = CNT_W'(DEFAULT_DIV);

  load_state_e      state, state_next;
  logic [CNT_W-1:0] pend_div, pend_next;
  logic [CNT_W-1:0] cur_div, cur_next;
  logic             ack_next, err_next;
  logic             load_ack, load_err;
  logic             wrap;
  logic             req_ok, req_bad;

  assign req_ok  = bus.div_load && (bus.div_val >= MIN_DIV_W);
  assign req_bad = bus.div_load && (bus.div_val <  MIN_DIV_W);

  clk_div_core #(.CNT_W(CNT_W)) u_core (
    .clk     (clk),
    .rst     (rst),
    .en      (bus.en),
    .div     (cur_div),
    .wrap    (wrap),
    .clk_out (bus.clk_out),
    .tick    (bus.tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pend_div <= '0;
      cur_div  <= DEF_DIV_W;
      load_ack <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_next;
      pend_div <= pend_next;
      cur_div  <= cur_next;
      load_ack <= ack_next;
      load_err <= err_next;
    end
  end

  // Apply first, then accept: on a load-and-wrap cycle the wrap commits the
  // previously pending ratio and the new request becomes the next pending one.
  always_comb begin
    state_next = state;
    pend_next  = pend_div;
    cur_next   = cur_div;
    ack_next   = 1'b0;
    err_next   = req_bad;
    if (state == PEND && wrap) begin
      cur_next   = pend_div;
      ack_next   = 1'b1;
      state_next = IDLE;
    end
    if (req_ok) begin
      pend_next  = bus.div_val;
      state_next = PEND;
    end
  end

  assign bus.load_ack  = load_ack;
  assign bus.load_err  = load_err;
  assign bus.cur_div   = cur_div;
  assign bus.dbg_state = logic'(state);
endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog (CNT_W=8, DEFAULT_DIV=4).
module tb_clk_div_prog;
  localparam int CNT_W = 8;
  localparam int EW    = CNT_W + 4;

  logic clk;
  logic rst;
  clk_div_if #(.CNT_W(CNT_W)) bus ();

  clk_div_prog #(.CNT_W(CNT_W), .DEFAULT_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs, exp_v;
  int n_cmp = 0;
  int n_bad = 0;

  // reference model: {cur_div, clk_out, tick, load_ack, load_err}
  int   m_cnt, m_cur, m_pend;
  bit   m_pend_v;
  logic m_clk;

  task automatic model_reset();
    m_cnt = 0; m_cur = 4; m_pend = 0; m_pend_v = 0; m_clk = 1'b0;
    exp_q.delete();
  endtask

  // Drive one cycle at the falling edge, predict the outputs that the next
  // rising edge produces, then wait until just after that edge.
  task automatic drive_cycle(input bit e, input bit ld, input int v);
    bit w, a, er;
    int nc;
    @(negedge clk);
    bus.en = e; bus.div_load = ld; bus.div_val = CNT_W'(v);
    w  = e && (m_cnt == m_cur - 1);
    a  = m_pend_v && w;
    er = ld && (v < 2);
    nc = a ? m_pend : m_cur;
    if (a) m_pend_v = 0;
    if (ld && v >= 2) begin m_pend = v; m_pend_v = 1; end
    if (e) begin
      m_cnt = w ? 0 : m_cnt + 1;
      m_clk = (m_cnt >= m_cur - m_cur / 2);
    end
    m_cur = nc;
    exp_q.push_back({CNT_W'(m_cur), m_clk, w, a, er});
    @(posedge clk);
    #1;
    bus.div_load = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.en = 1'b0; bus.div_load = 1'b0; bus.div_val = '0;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; bus.en = 1'b0; bus.div_load = 1'b0; bus.div_val = '0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    obs = {bus.cur_div, bus.clk_out, bus.tick, bus.load_ack, bus.load_err};
    n_cmp++;
    if (obs !== {8'd4, 4'b0000}) begin
      n_bad++; $display("FAIL reset_outputs act=%h exp=%h", obs, {8'd4, 4'b0000});
    end
    n_cmp++;
    if (bus.dbg_state !== 1'b0) begin
      n_bad++; $display("FAIL reset_state act=%b exp=0", bus.dbg_state);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_default_div();
    int ticks = 0, falls = 0;
    logic prev = 1'b0;
    logic [15:0] seq;
    for (int i = 0; i < 16; i++) begin
      drive_cycle(1, 0, 0);
      obs = {bus.cur_div, bus.clk_out, bus.tick, bus.load_ack, bus.load_err};
      exp_v = exp_q.pop_front(); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL default_cyc%0d act=%h exp=%h", i, obs, exp_v); end
      seq[i] = bus.clk_out;
      if (bus.tick) ticks++;
      if (bus.tick && prev && !bus.clk_out) falls++;
      prev = bus.clk_out;
    end
    n_cmp++;
    if (seq !== 16'b0110_0110_0110_0110) begin n_bad++; $display("FAIL default_wave act=%b exp=%b", seq, 16'b0110_0110_0110_0110); end
    n_cmp++;
    if (ticks != 4 || falls != 4) begin n_bad++; $display("FAIL default_tick act=%0d/%0d exp=4/4", ticks, falls); end
  endtask

  task automatic test_load_err();
    int errs = 0, acks = 0;
    for (int i = 0; i < 12; i++) begin
      drive_cycle(1, (i == 1 || i == 3), (i == 1) ? 1 : 0);
      obs = {bus.cur_div, bus.clk_out, bus.tick, bus.load_ack, bus.load_err};
      exp_v = exp_q.pop_front(); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL err_cyc%0d act=%h exp=%h", i, obs, exp_v); end
      if (bus.load_err) errs++;
      if (bus.load_ack) acks++;
    end
    n_cmp++;
    if (errs != 2 || acks != 0 || bus.cur_div !== 8'd4) begin
      n_bad++; $display("FAIL err_summary act=err%0d ack%0d cur%0d exp=err2 ack0 cur4", errs, acks, bus.cur_div);
    end
  endtask

  task automatic test_ratio(input int n);
    int lat = 0, highs = 0, ticks = 0, old_n;
    bit got = 0;
    old_n = m_cur;
    drive_cycle(1, 1, n);
    obs = {bus.cur_div, bus.clk_out, bus.tick, bus.load_ack, bus.load_err};
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL ratio%0d_load act=%h exp=%h", n, obs, exp_v); end
    got = bus.load_ack; lat = 1;
    while (!got && lat <= old_n + 1) begin
      drive_cycle(1, 0, 0);
      obs = {bus.cur_div, bus.clk_out, bus.tick, bus.load_ack, bus.load_err};
      exp_v = exp_q.pop_front(); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL ratio%0d_wait act=%h exp=%h", n, obs, exp_v); end
      got = bus.load_ack; lat++;
    end
    n_cmp++;
    if (!got || bus.cur_div !== CNT_W'(n)) begin
      n_bad++; $display("FAIL ratio%0d_ack act=ack%0d cur%0d exp=ack1 cur%0d", n, got, bus.cur_div, n);
    end
    for (int i = 0; i < 2 * n; i++) begin
      drive_cycle(1, 0, 0);
      obs = {bus.cur_div, bus.clk_out, bus.tick, bus.load_ack, bus.load_err};
      exp_v = exp_q.pop_front(); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL ratio%0d_cyc%0d act=%h exp=%h", n, i, obs, exp_v); end
      if (bus.clk_out) highs++;
      if (bus.tick) ticks++;
    end
    n_cmp++;
    if (highs != 2 * (n / 2) || ticks != 2) begin
      n_bad++; $display("FAIL ratio%0d_duty act=hi%0d tk%0d exp=hi%0d tk2", n, highs, ticks, 2 * (n / 2));
    end
  endtask

  task automatic test_back_to_back();
    int acks = 0, cyc = 0;
    bit got = 0;
    // align to the start of a period
    for (int i = 0; i < 20 && m_cnt != 0; i++) begin
      drive_cycle(1, 0, 0);
      obs = {bus.cur_div, bus.clk_out, bus.tick, bus.load_ack, bus.load_err};
      exp_v = exp_q.pop_front(); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL b2b_align act=%h exp=%h", obs, exp_v); end
    end
    for (int i = 0; i < 18; i++) begin
      drive_cycle(1, (i < 2), (i == 0) ? 6 : 9);
      obs = {bus.cur_div, bus.clk_out, bus.tick, bus.load_ack, bus.load_err};
      exp_v = exp_q.pop_front(); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL b2b_cyc%0d act=%h exp=%h", i, obs, exp_v); end
      if (bus.load_ack) acks++;
    end
    n_cmp++;
    if (acks != 1 || bus.cur_div !== 8'd9) begin
      n_bad++; $display("FAIL overwrite act=ack%0d cur%0d exp=ack1 cur9", acks, bus.cur_div);
    end
    // load exactly on the wrap cycle: must wait a whole further period
    for (int i = 0; i < 20 && m_cnt != m_cur - 1; i++) begin
      drive_cycle(1, 0, 0);
      obs = {bus.cur_div, bus.clk_out, bus.tick, bus.load_ack, bus.load_err};
      exp_v = exp_q.pop_front(); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL wrapload_align act=%h exp=%h", obs, exp_v); end
    end
    drive_cycle(1, 1, 3);
    obs = {bus.cur_div, bus.clk_out, bus.tick, bus.load_ack, bus.load_err};
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL wrapload_load act=%h exp=%h", obs, exp_v); end
    n_cmp++;
    if (bus.tick !== 1'b1 || bus.load_ack !== 1'b0) begin
      n_bad++; $display("FAIL wrapload_same act=tick%b ack%b exp=tick1 ack0", bus.tick, bus.load_ack);
    end
    while (!got && cyc < 12) begin
      drive_cycle(1, 0, 0);
      obs = {bus.cur_div, bus.clk_out, bus.tick, bus.load_ack, bus.load_err};
      exp_v = exp_q.pop_front(); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL wrapload_wait act=%h exp=%h", obs, exp_v); end
      got = bus.load_ack; cyc++;
    end
    n_cmp++;
    if (!got || cyc != 9 || bus.cur_div !== 8'd3) begin
      n_bad++; $display("FAIL wrapload_apply act=cyc%0d cur%0d exp=cyc9 cur3", cyc, bus.cur_div);
    end
  endtask

  task automatic test_enable_freeze();
    // N=3: freeze during the high cycle (cnt=2)
    for (int i = 0; i < 10 && m_cnt != 2; i++) begin
      drive_cycle(1, 0, 0);
      obs = {bus.cur_div, bus.clk_out, bus.tick, bus.load_ack, bus.load_err};
      exp_v = exp_q.pop_front(); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL freeze_align act=%h exp=%h", obs, exp_v); end
    end
    for (int i = 0; i < 10; i++) begin
      drive_cycle(0, 0, 0);
      obs = {bus.cur_div, bus.clk_out, bus.tick, bus.load_ack, bus.load_err};
      exp_v = exp_q.pop_front(); n_cmp++;
      if (obs !== exp_v || bus.clk_out !== 1'b1 || bus.tick !== 1'b0) begin
        n_bad++; $display("FAIL freeze_cyc%0d act=%h exp=%h", i, obs, exp_v);
      end
    end
    drive_cycle(1, 0, 0);
    obs = {bus.cur_div, bus.clk_out, bus.tick, bus.load_ack, bus.load_err};
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v || bus.tick !== 1'b1 || bus.clk_out !== 1'b0) begin
      n_bad++; $display("FAIL freeze_resume act=%h exp=%h", obs, exp_v);
    end
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1, 0, 0);
      obs = {bus.cur_div, bus.clk_out, bus.tick, bus.load_ack, bus.load_err};
      exp_v = exp_q.pop_front(); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL resume_cyc%0d act=%h exp=%h", i, obs, exp_v); end
    end
  endtask

  task automatic test_reset_mid_pend();
    int acks = 0;
    drive_cycle(1, 1, 10);
    obs = {bus.cur_div, bus.clk_out, bus.tick, bus.load_ack, bus.load_err};
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL rstpend_load act=%h exp=%h", obs, exp_v); end
    n_cmp++;
    if (bus.dbg_state !== 1'b1) begin n_bad++; $display("FAIL rstpend_state act=%b exp=1", bus.dbg_state); end
    #2 rst = 1'b0;
    #1;
    obs = {bus.cur_div, bus.clk_out, bus.tick, bus.load_ack, bus.load_err};
    n_cmp++;
    if (obs !== {8'd4, 4'b0000} || bus.dbg_state !== 1'b0) begin
      n_bad++; $display("FAIL rstpend_async act=%h st%b exp=%h st0", obs, bus.dbg_state, {8'd4, 4'b0000});
    end
    bus.en = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 24; i++) begin
      drive_cycle(1, 0, 0);
      obs = {bus.cur_div, bus.clk_out, bus.tick, bus.load_ack, bus.load_err};
      exp_v = exp_q.pop_front(); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL rstpend_cyc%0d act=%h exp=%h", i, obs, exp_v); end
      if (bus.load_ack) acks++;
    end
    n_cmp++;
    if (acks != 0 || bus.cur_div !== 8'd4) begin
      n_bad++; $display("FAIL rstpend_discard act=ack%0d cur%0d exp=ack0 cur4", acks, bus.cur_div);
    end
  endtask

  initial begin
    test_reset();
    test_default_div();
    test_load_err();
    test_ratio(5);
    test_ratio(7);
    test_back_to_back();
    test_enable_freeze();
    test_reset_mid_pend();
    do_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "timeout");
  end
endmodule
